// File: rtl/id_stage_pipe.sv
// RV32/RV64 instruction-decode stage with an ID/EX register, valid/ready handshakes,
// single-bubble load-use stall and redirect flush.
module id_stage_pipe #(
  parameter int  XLEN = 64,
  localparam int SHW  = (XLEN == 64) ? 6 : 5
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [XLEN-1:0] InstAddrIn,
  input  logic [31:0]     InstIn,
  output logic [4:0]      Rs1AddrOut,
  output logic [4:0]      Rs2AddrOut,
  output logic            Rs1ReadEnable,
  output logic            Rs2ReadEnable,
  input  logic [XLEN-1:0] Rs1ReadDataIn,
  input  logic [XLEN-1:0] Rs2ReadDataIn,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] InstAddrOut,
  output logic [XLEN-1:0] Rs1DataOut,
  output logic [XLEN-1:0] Rs2DataOut,
  output logic [XLEN-1:0] Imm,
  output logic [4:0]      RdAddrOut,
  output logic            RdWriteEnable,
  output logic            IsLoad,
  output logic [6:0]      OpCode,
  output logic [2:0]      Funct3,
  output logic [6:0]      Funct7,
  output logic [SHW-1:0]  Shamt,
  output logic            IllegalInst
);

  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcFence   = 7'b0001111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam bit         Rv64       = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore;
  logic isOpImm, isOp, isFence, isSystem, isOpImm32, isOp32;
  logic isShift, legal, rdWe;

  assign opcode    = InstIn[6:0];
  assign funct3    = InstIn[14:12];
  assign isLui     = (opcode == OpcLui);
  assign isAuipc   = (opcode == OpcAuipc);
  assign isJal     = (opcode == OpcJal);
  assign isJalr    = (opcode == OpcJalr);
  assign isBranch  = (opcode == OpcBranch);
  assign isLoad    = (opcode == OpcLoad);
  assign isStore   = (opcode == OpcStore);
  assign isOpImm   = (opcode == OpcOpImm);
  assign isOp      = (opcode == OpcOp);
  assign isFence   = (opcode == OpcFence);
  assign isSystem  = (opcode == OpcSystem);
  // The word-sized opcodes only exist on RV64; on RV32 they decode as illegal.
  assign isOpImm32 = Rv64 && (opcode == OpcOpImm32);
  assign isOp32    = Rv64 && (opcode == OpcOp32);
  assign isShift   = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign rdWe  = isLui | isAuipc | isJal | isJalr | isLoad | isOpImm | isOp |
                 isFence | isSystem | isOpImm32 | isOp32;
  assign legal = rdWe | isBranch | isStore;

  assign Rs1ReadEnable = isJalr | isBranch | isLoad | isStore | isOpImm | isOp |
                         isFence | isSystem | isOpImm32 | isOp32;
  assign Rs2ReadEnable = isBranch | isStore | isOp | isOp32;
  assign Rs1AddrOut    = Rs1ReadEnable ? InstIn[19:15] : 5'd0;
  assign Rs2AddrOut    = Rs2ReadEnable ? InstIn[24:20] : 5'd0;

  logic [31:0] imm32I, imm32S, imm32B, imm32J, imm32U, imm32Sel;
  logic [XLEN-1:0] immDec;
  logic [SHW-1:0]  shamtDec;

  assign imm32I = {{20{InstIn[31]}}, InstIn[31:20]};
  assign imm32S = {{20{InstIn[31]}}, InstIn[31:25], InstIn[11:7]};
  assign imm32B = {{19{InstIn[31]}}, InstIn[31], InstIn[7], InstIn[30:25], InstIn[11:8], 1'b0};
  assign imm32J = {{11{InstIn[31]}}, InstIn[31], InstIn[19:12], InstIn[20], InstIn[30:21], 1'b0};
  assign imm32U = {InstIn[31:12], 12'b0};

  always_comb begin
    imm32Sel = '0;
    if (isJalr || isLoad || isOpImm || isFence || isSystem || isOpImm32) imm32Sel = imm32I;
    else if (isStore)                                                     imm32Sel = imm32S;
    else if (isBranch)                                                    imm32Sel = imm32B;
    else if (isJal)                                                       imm32Sel = imm32J;
    else if (isLui || isAuipc)                                            imm32Sel = imm32U;
  end

  // Every immediate is already sign-extended to 32 bits; widen once to XLEN.
  assign immDec = XLEN'($signed(imm32Sel));

  always_comb begin
    shamtDec = '0;
    if (isOpImm && isShift)        shamtDec = InstIn[20 +: SHW];
    else if (isOpImm32 && isShift) shamtDec = SHW'(InstIn[24:20]);
  end

  logic slotFree, hazard;

  assign slotFree = !OutValid || OutReady;
  assign hazard   = OutValid && IsLoad && (RdAddrOut != 5'd0) &&
                    ((Rs1ReadEnable && (Rs1AddrOut == RdAddrOut)) ||
                     (Rs2ReadEnable && (Rs2AddrOut == RdAddrOut)));
  assign InReady  = slotFree && !hazard && !Flush;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OutValid      <= 1'b0;
      InstAddrOut   <= '0;
      Rs1DataOut    <= '0;
      Rs2DataOut    <= '0;
      Imm           <= '0;
      RdAddrOut     <= '0;
      RdWriteEnable <= 1'b0;
      IsLoad        <= 1'b0;
      OpCode        <= '0;
      Funct3        <= '0;
      Funct7        <= '0;
      Shamt         <= '0;
      IllegalInst   <= 1'b0;
    end else if (Flush) begin
      OutValid <= 1'b0;
    end else if (slotFree && hazard) begin
      // Bubble: the load drains, the dependent instruction waits at the input.
      OutValid <= 1'b0;
    end else if (slotFree && InValid) begin
      OutValid      <= 1'b1;
      InstAddrOut   <= InstAddrIn;
      Rs1DataOut    <= Rs1ReadDataIn;
      Rs2DataOut    <= Rs2ReadDataIn;
      Imm           <= immDec;
      RdAddrOut     <= rdWe ? InstIn[11:7] : 5'd0;
      RdWriteEnable <= rdWe;
      IsLoad        <= isLoad;
      OpCode        <= opcode;
      Funct3        <= funct3;
      Funct7        <= InstIn[31:25];
      Shamt         <= shamtDec;
      IllegalInst   <= !legal;
    end else if (slotFree) begin
      OutValid <= 1'b0;
    end
  end

endmodule
